// File: rtl/prefetch_queue_if.sv
// Instruction-memory request/response bus between the prefetch queue and imem.
interface prefetch_queue_if #(
   parameter int DATA_W = 32
);
   logic              imem_valid;
   logic [31:0]       imem_addr;
   logic [1:0]        imem_mode;
   logic              imem_instr;
   logic              imem_ready;
   logic [DATA_W-1:0] imem_rdata;
   logic              imem_error;

   modport master (
      output imem_valid, imem_addr, imem_mode, imem_instr,
      input  imem_ready, imem_rdata, imem_error
   );

   modport slave (
      input  imem_valid, imem_addr, imem_mode, imem_instr,
      output imem_ready, imem_rdata, imem_error
   );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: streams sequential imem requests into a small FIFO,
// serves one word per consumer request, and drops stale responses after a redirect.
module prefetch_queue #(
   parameter int DEPTH_LOG = 2,
   parameter int DATA_W    = 32,
   parameter int MAX_OUT   = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 fetch_valid,
   input  logic                 fetch_spec,
   input  logic [31:0]          fetch_addr,
   input  logic [1:0]           fetch_mode,
   output logic [DATA_W-1:0]    fetch_rdata,
   output logic [31:0]          fetch_pc,
   output logic                 fetch_error,
   output logic                 fetch_ready,
   output logic [DEPTH_LOG:0]   count,
   prefetch_queue_if.master     imem
);

   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam int STEP  = DATA_W / 8;
   localparam int ALIGN = $clog2(STEP);
   localparam int OUT_W = $clog2(MAX_OUT + 1);
   localparam int CW    = DEPTH_LOG + 1;
   localparam int ENT_W = 1 + 32 + DATA_W;
   localparam logic [31:0] ALIGN_MASK = 32'((1 << ALIGN) - 1);

   logic [ENT_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG-1:0] wptr, rptr;
   logic [DEPTH_LOG:0]   cnt;
   logic [OUT_W-1:0]     outst, drop;
   logic                 pending;
   logic [31:0]          next_addr;
   logic [1:0]           mode;

   logic                 ready_q, error_q;
   logic [31:0]          pc_q;
   logic [DATA_W-1:0]    rdata_q;

   logic                 want, issue, resp_new, resp_old, push, pop;
   logic [31:0]          oldest_pc;

   // outst counts only requests of the current stream; drop counts stale ones.
   always_comb begin
      want      = pending | fetch_valid;
      issue     = !reset && !fetch_spec
                  && ((32'(outst) + 32'(drop)) < 32'(MAX_OUT))
                  && ((32'(cnt) + 32'(outst)) < 32'(DEPTH));
      resp_new  = imem.imem_ready && (drop == '0);
      resp_old  = imem.imem_ready && (drop != '0);
      push      = resp_new && !fetch_spec && !reset;
      pop       = want && (cnt != '0) && !fetch_spec;
      oldest_pc = next_addr - (32'(outst) * 32'(STEP));
   end

   assign imem.imem_valid = issue;
   assign imem.imem_addr  = next_addr;
   assign imem.imem_mode  = mode;
   assign imem.imem_instr = 1'b1;

   assign fetch_ready = ready_q & ~reset;
   assign fetch_error = error_q & ~reset;
   assign fetch_pc    = reset ? '0 : pc_q;
   assign fetch_rdata = reset ? '0 : rdata_q;
   assign count       = reset ? '0 : cnt;

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wptr] <= {imem.imem_error, oldest_pc, imem.imem_rdata};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr      <= '0;
         rptr      <= '0;
         cnt       <= '0;
         outst     <= '0;
         drop      <= '0;
         pending   <= 1'b0;
         next_addr <= '0;
         mode      <= 2'b11;
         ready_q   <= 1'b0;
         error_q   <= 1'b0;
         pc_q      <= '0;
         rdata_q   <= '0;
      end else begin
         ready_q <= pop;
         if (pop) begin
            {error_q, pc_q, rdata_q} <= mem[rptr];
         end
         if (fetch_spec) begin
            // A response in this cycle retires one in-flight request; the rest go stale.
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            pending   <= 1'b0;
            drop      <= drop + outst - OUT_W'(imem.imem_ready);
            outst     <= '0;
            next_addr <= fetch_addr & ~ALIGN_MASK;
            mode      <= fetch_mode;
         end else begin
            if (push) wptr <= wptr + DEPTH_LOG'(1);
            if (pop)  rptr <= rptr + DEPTH_LOG'(1);
            cnt     <= cnt + CW'(push) - CW'(pop);
            pending <= want && !pop;
            outst   <= outst + OUT_W'(issue) - OUT_W'(resp_new);
            drop    <= drop - OUT_W'(resp_old);
            if (issue) next_addr <= next_addr + 32'(STEP);
         end
      end
   end

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue against a queue-based model of the fetch stream.
module tb_prefetch_queue;

   localparam int DEPTH   = 4;
   localparam int MAX_OUT = 2;

   typedef struct { logic [31:0] addr; bit stale; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] data; logic err; } ent_t;

   logic        clock = 1'b0;
   logic        reset, fetch_valid, fetch_spec;
   logic [31:0] fetch_addr;
   logic [1:0]  fetch_mode;
   logic [31:0] fetch_rdata, fetch_pc;
   logic        fetch_error, fetch_ready;
   logic [2:0]  count;

   prefetch_queue_if #(.DATA_W(32)) imem_bus ();

   prefetch_queue #(.DEPTH_LOG(2), .DATA_W(32), .MAX_OUT(MAX_OUT)) dut (
      .clock       (clock),
      .reset       (reset),
      .fetch_valid (fetch_valid),
      .fetch_spec  (fetch_spec),
      .fetch_addr  (fetch_addr),
      .fetch_mode  (fetch_mode),
      .fetch_rdata (fetch_rdata),
      .fetch_pc    (fetch_pc),
      .fetch_error (fetch_error),
      .fetch_ready (fetch_ready),
      .count       (count),
      .imem        (imem_bus)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // reference model state
   req_t        inflight[$];
   ent_t        q[$];
   bit          m_pending;
   logic [31:0] m_next;
   logic [1:0]  m_mode;

   bit          exp_ivalid, exp_ready, exp_err;
   logic [31:0] exp_iaddr, exp_pc, exp_data;
   logic [1:0]  exp_imode;
   int          exp_count;

   logic        obs_ivalid, obs_instr, obs_ready, obs_err;
   logic [31:0] obs_iaddr, obs_pc, obs_data;
   logic [1:0]  obs_imode;
   logic [2:0]  obs_count;

   function automatic logic [31:0] wdata(logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
   endfunction

   function automatic logic werr(logic [31:0] a);
      return (a == 32'h104) || (a == 32'h1F0);
   endfunction

   function automatic int fresh();
      int n = 0;
      foreach (inflight[i]) if (!inflight[i].stale) n++;
      return n;
   endfunction

   // One clock cycle: drive inputs, sample combinational outputs, step model, sample registered outputs.
   task automatic tick(input bit fv, input bit spec, input logic [31:0] saddr,
                       input logic [1:0] smode, input bit rsp, input bit rst);
      bit   do_rsp, want;
      req_t head, r;
      ent_t ent;
      reset       = rst;
      fetch_valid = fv;
      fetch_spec  = spec;
      fetch_addr  = saddr;
      fetch_mode  = smode;
      do_rsp = rsp && !rst && (inflight.size() > 0);
      if (do_rsp) begin
         head = inflight[0];
         imem_bus.imem_ready = 1'b1;
         imem_bus.imem_rdata = wdata(head.addr);
         imem_bus.imem_error = werr(head.addr);
      end else begin
         imem_bus.imem_ready = 1'b0;
         imem_bus.imem_rdata = $urandom;
         imem_bus.imem_error = 1'($urandom_range(0, 1));
      end
      #2;
      obs_ivalid = imem_bus.imem_valid;
      obs_iaddr  = imem_bus.imem_addr;
      obs_imode  = imem_bus.imem_mode;
      obs_instr  = imem_bus.imem_instr;
      obs_count  = count;

      exp_ivalid = !rst && !spec && (inflight.size() < MAX_OUT) && ((q.size() + fresh()) < DEPTH);
      exp_iaddr  = m_next;
      exp_imode  = m_mode;
      exp_count  = rst ? 0 : q.size();
      exp_ready  = 1'b0;
      if (rst) begin
         q.delete();
         inflight.delete();
         m_pending = 1'b0;
         m_next    = 32'h0;
         m_mode    = 2'b11;
         exp_pc    = 32'h0;
         exp_data  = 32'h0;
         exp_err   = 1'b0;
      end else begin
         want = m_pending || fv;
         if (!spec && want && q.size() > 0) begin
            ent       = q.pop_front();
            exp_ready = 1'b1;
            exp_pc    = ent.pc;
            exp_data  = ent.data;
            exp_err   = ent.err;
         end
         if (do_rsp) begin
            head = inflight.pop_front();
            if (!head.stale && !spec) begin
               ent.pc   = head.addr;
               ent.data = wdata(head.addr);
               ent.err  = werr(head.addr);
               q.push_back(ent);
            end
         end
         if (spec) begin
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            q.delete();
            m_pending = 1'b0;
            m_next    = saddr & 32'hFFFF_FFFC;
            m_mode    = smode;
         end else begin
            m_pending = want && !exp_ready;
            if (exp_ivalid) begin
               r.addr  = m_next;
               r.stale = 1'b0;
               inflight.push_back(r);
               m_next  = m_next + 32'd4;
            end
         end
      end
      @(posedge clock);
      #1;
      obs_ready = fetch_ready;
      obs_pc    = fetch_pc;
      obs_data  = fetch_rdata;
      obs_err   = fetch_error;
   endtask

   task automatic test_reset();
      tick(0, 0, 32'h0, 2'b00, 0, 1);
      tick(0, 0, 32'h0, 2'b00, 0, 1);
      checks++; if (obs_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", obs_count); end
      checks++; if (obs_ivalid !== 1'b0) begin errors++; $display("FAIL reset_imem_valid got %b want 0", obs_ivalid); end
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL reset_fetch_ready got %b want 0", obs_ready); end
      checks++; if (obs_pc !== 32'h0) begin errors++; $display("FAIL reset_fetch_pc got %h want 0", obs_pc); end
      checks++; if (obs_data !== 32'h0) begin errors++; $display("FAIL reset_fetch_rdata got %h want 0", obs_data); end
      checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL reset_fetch_error got %b want 0", obs_err); end
      tick(0, 0, 32'h0, 2'b00, 0, 0);
      checks++; if (obs_ivalid !== 1'b1) begin errors++; $display("FAIL post_reset_issue got %b want 1", obs_ivalid); end
      checks++; if (obs_iaddr !== 32'h0) begin errors++; $display("FAIL post_reset_addr got %h want 0", obs_iaddr); end
      checks++; if (obs_imode !== 2'b11) begin errors++; $display("FAIL post_reset_mode got %b want 11", obs_imode); end
      checks++; if (obs_instr !== 1'b1) begin errors++; $display("FAIL imem_instr got %b want 1", obs_instr); end
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL post_reset_ready got %b want 0", obs_ready); end
   endtask

   task automatic test_redirect_stream();
      int n = 0;
      tick(0, 1, 32'h100, 2'b00, 0, 0);
      for (int c = 0; c < 12; c++) begin
         tick(1, 0, 32'h0, 2'b00, 1, 0);
         checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL stream_ready got %b want %b", obs_ready, exp_ready); end
         if (obs_ready === 1'b1) begin
            checks++; if (obs_pc !== 32'h100 + 32'(4 * n)) begin errors++; $display("FAIL stream_pc got %h want %h", obs_pc, 32'h100 + 32'(4 * n)); end
            checks++; if (obs_data !== wdata(32'h100 + 32'(4 * n))) begin errors++; $display("FAIL stream_data got %h want %h", obs_data, wdata(32'h100 + 32'(4 * n))); end
            n++;
         end
      end
      checks++; if (n < 3) begin errors++; $display("FAIL stream_deliveries got %0d want >=3", n); end
   endtask

   task automatic test_fill_wrap();
      tick(0, 1, 32'h40, 2'b01, 0, 0);
      for (int c = 0; c < 10; c++) tick(0, 0, 32'h0, 2'b00, 1, 0);
      tick(0, 0, 32'h0, 2'b00, 1, 0);
      checks++; if (obs_count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", obs_count); end
      checks++; if (obs_ivalid !== 1'b0) begin errors++; $display("FAIL fill_imem_valid got %b want 0", obs_ivalid); end
      for (int k = 0; k < 8; k++) begin
         tick(1, 0, 32'h0, 2'b00, 1, 0);
         checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready got %b want 1", obs_ready); end
         checks++; if (obs_pc !== 32'h40 + 32'(4 * k)) begin errors++; $display("FAIL wrap_pc got %h want %h", obs_pc, 32'h40 + 32'(4 * k)); end
      end
   endtask

   task automatic test_redirect_drop();
      bit seen = 1'b0;
      tick(0, 1, 32'h1000, 2'b00, 0, 0);
      tick(0, 0, 32'h0, 2'b00, 0, 0);
      tick(0, 0, 32'h0, 2'b00, 0, 0);
      tick(0, 0, 32'h0, 2'b00, 0, 0);
      checks++; if (obs_ivalid !== 1'b0) begin errors++; $display("FAIL max_out_limit got %b want 0", obs_ivalid); end
      tick(0, 1, 32'h200, 2'b10, 0, 0);
      tick(1, 0, 32'h0, 2'b00, 1, 0);
      checks++; if (obs_ivalid !== 1'b0) begin errors++; $display("FAIL drop_inflight_limit got %b want 0", obs_ivalid); end
      for (int c = 0; c < 12; c++) begin
         tick(1, 0, 32'h0, 2'b00, 1, 0);
         if (obs_ready === 1'b1 && !seen) begin
            seen = 1'b1;
            checks++; if (obs_pc !== 32'h200) begin errors++; $display("FAIL drop_first_pc got %h want 00000200", obs_pc); end
         end
      end
      checks++; if (!seen) begin errors++; $display("FAIL drop_delivery got none want one"); end
   endtask

   task automatic test_spec_collision();
      bit seen = 1'b0;
      tick(0, 1, 32'h300, 2'b00, 0, 0);
      tick(0, 0, 32'h0, 2'b00, 1, 0);
      tick(0, 0, 32'h0, 2'b00, 1, 0);
      tick(1, 1, 32'h400, 2'b00, 1, 0);
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL collide_ready got %b want 0", obs_ready); end
      tick(0, 0, 32'h0, 2'b00, 1, 0);
      checks++; if (obs_count !== 3'd0) begin errors++; $display("FAIL collide_count got %0d want 0", obs_count); end
      for (int c = 0; c < 10; c++) begin
         tick(1, 0, 32'h0, 2'b00, 1, 0);
         if (obs_ready === 1'b1 && !seen) begin
            seen = 1'b1;
            checks++; if (obs_pc !== 32'h400) begin errors++; $display("FAIL collide_first_pc got %h want 00000400", obs_pc); end
         end
      end
      checks++; if (!seen) begin errors++; $display("FAIL collide_delivery got none want one"); end
   endtask

   task automatic test_error();
      bit seen = 1'b0;
      tick(0, 1, 32'hF8, 2'b00, 0, 0);
      for (int c = 0; c < 12; c++) begin
         tick(1, 0, 32'h0, 2'b00, 1, 0);
         if (obs_ready === 1'b1) begin
            checks++; if (obs_err !== (obs_pc == 32'h104)) begin errors++; $display("FAIL error_flag pc %h got %b want %b", obs_pc, obs_err, obs_pc == 32'h104); end
            if (obs_pc == 32'h104) seen = 1'b1;
         end
      end
      checks++; if (!seen) begin errors++; $display("FAIL error_word got missing want pc 00000104"); end
   endtask

   task automatic test_reset_mid();
      bit reached = 1'b0;
      tick(0, 1, 32'h500, 2'b00, 0, 0);
      for (int c = 0; c < 20 && !reached; c++) begin
         tick(0, 0, 32'h0, 2'b00, 1, 0);
         if (q.size() == 3) reached = 1'b1;
      end
      checks++; if (!reached) begin errors++; $display("FAIL mid_fill got %0d want 3", q.size()); end
      tick(0, 0, 32'h0, 2'b00, 0, 0);
      checks++; if (obs_count !== 3'd3) begin errors++; $display("FAIL mid_count got %0d want 3", obs_count); end
      tick(1, 0, 32'h0, 2'b00, 0, 1);
      checks++; if (obs_ivalid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", obs_ivalid); end
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got %b want 0", obs_ready); end
      tick(0, 0, 32'h0, 2'b00, 0, 0);
      checks++; if (obs_count !== 3'd0) begin errors++; $display("FAIL mid_after_count got %0d want 0", obs_count); end
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL mid_after_ready got %b want 0", obs_ready); end
   endtask

   task automatic test_random();
      bit          fv, sp, rs, rt;
      logic [31:0] a;
      for (int c = 0; c < 600; c++) begin
         fv = ($urandom_range(0, 1) == 1);
         sp = ($urandom_range(0, 19) == 0);
         rs = ($urandom_range(0, 9) < 6);
         rt = ($urandom_range(0, 99) == 0);
         a  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : 32'($urandom_range(0, 511));
         tick(fv, sp, a, 2'($urandom_range(0, 3)), rs, rt);
         checks++; if (obs_ivalid !== exp_ivalid) begin errors++; $display("FAIL rnd_imem_valid cyc %0d got %b want %b", c, obs_ivalid, exp_ivalid); end
         if (exp_ivalid) begin
            checks++; if (obs_iaddr !== exp_iaddr) begin errors++; $display("FAIL rnd_imem_addr cyc %0d got %h want %h", c, obs_iaddr, exp_iaddr); end
            checks++; if (obs_imode !== exp_imode) begin errors++; $display("FAIL rnd_imem_mode cyc %0d got %b want %b", c, obs_imode, exp_imode); end
         end
         checks++; if (32'(obs_count) !== 32'(exp_count)) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, obs_count, exp_count); end
         checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, obs_ready, exp_ready); end
         if (exp_ready) begin
            checks++; if (obs_pc !== exp_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", c, obs_pc, exp_pc); end
            checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", c, obs_data, exp_data); end
            checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL rnd_error cyc %0d got %b want %b", c, obs_err, exp_err); end
         end
      end
   endtask

   initial begin
      reset               = 1'b1;
      fetch_valid         = 1'b0;
      fetch_spec          = 1'b0;
      fetch_addr          = 32'h0;
      fetch_mode          = 2'b00;
      imem_bus.imem_ready = 1'b0;
      imem_bus.imem_rdata = 32'h0;
      imem_bus.imem_error = 1'b0;
      m_pending           = 1'b0;
      m_next              = 32'h0;
      m_mode              = 2'b11;
      test_reset();
      test_redirect_stream();
      test_fill_wrap();
      test_redirect_drop();
      test_spec_collision();
      test_error();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
